// File: rtl/kbd_typeahead_pkg.sv
// Shared types and constants for the keyboard type-ahead buffer.
package kbd_pkg;
    localparam int unsigned KBD_STRB_BIT = 7;
    localparam int unsigned KBD_CODE_W   = 7;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CLEAR    = 2'd1,
        WAIT_LOW = 2'd2
    } kbd_ack_state_t;
endpackage

// File: rtl/kbd_typeahead_if.sv
// Controller-side and CPU-side signals of the type-ahead buffer.
interface kbd_typeahead_if #(
    parameter int unsigned DEPTH = 16
);
    logic [7:0]              kbd_in;
    logic                    kbd_clr_out;
    logic                    clr_strb;
    logic                    flush;
    logic [7:0]              dout;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic                    overflow;

    modport master (
        output kbd_in, clr_strb, flush,
        input  kbd_clr_out, dout, fifo_count, overflow
    );

    modport slave (
        input  kbd_in, clr_strb, flush,
        output kbd_clr_out, dout, fifo_count, overflow
    );
endinterface

// File: rtl/kbd_typeahead_fifo.sv
// Synchronous FIFO of key codes; flush overrides push and pop in the same cycle.
module typeahead_fifo
    import kbd_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    input  logic [KBD_CODE_W-1:0] wdata_i,
    output logic [KBD_CODE_W-1:0] rdata_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [CW-1:0]         count_o
);
    logic [KBD_CODE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A full FIFO still accepts a push when a pop frees the slot on the same edge.
    assign pop_ok  = pop_i && !empty_o && !flush_i;
    assign push_ok = push_i && (!full_o || pop_ok) && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok) count_d = count_q + 1'b1;
            if (pop_ok && !push_ok) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end
endmodule

// File: rtl/kbd_typeahead.sv
// Type-ahead buffer: acknowledges PS/2 controller keys, queues them, and
// presents an Apple-style strobe/key register to the CPU.
module kbd_typeahead
    import kbd_pkg::*;
#(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned CLR_CYCLES   = 4,
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input  logic            clock,
    input  logic            reset_n,
    kbd_typeahead_if.slave  bus
);
    localparam int unsigned CW   = $clog2(DEPTH) + 1;
    localparam int unsigned TMAX = (CLR_CYCLES > WAIT_TIMEOUT) ? CLR_CYCLES : WAIT_TIMEOUT;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    kbd_ack_state_t        state_q, state_d;
    logic [TW-1:0]         cnt_q, cnt_d;
    logic [1:0]            sync_q;
    logic [7:0]            dout_q, dout_d;
    logic                  ovf_q, ovf_d;
    logic                  strb_s, push, pop, full, empty;
    logic [KBD_CODE_W-1:0] head_code;
    logic [CW-1:0]         count;

    assign strb_s          = sync_q[1];
    assign bus.kbd_clr_out = (state_q == CLEAR);
    assign bus.dout        = dout_q;
    assign bus.fifo_count  = count;
    assign bus.overflow    = ovf_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (strb_s) begin
                    push    = 1'b1;
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == TW'(CLR_CYCLES - 1)) begin
                    state_d = WAIT_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_LOW: begin
                // A strobe stuck high gets another clear pulse but is never re-pushed.
                if (!strb_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == TW'(WAIT_TIMEOUT - 1)) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // CPU strobe clear beats a refill so the strobe drops for a cycle between keys.
    assign pop = !dout_q[KBD_STRB_BIT] && !empty && !bus.clr_strb && !bus.flush;

    always_comb begin
        dout_d = dout_q;
        ovf_d  = ovf_q;
        if (bus.flush) begin
            dout_d[KBD_STRB_BIT] = 1'b0;
            ovf_d                = 1'b0;
        end else begin
            if (bus.clr_strb)   dout_d[KBD_STRB_BIT] = 1'b0;
            else if (pop)       dout_d = {1'b1, head_code};
            if (push && full && !pop) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            sync_q  <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sync_q  <= {sync_q[0], bus.kbd_in[KBD_STRB_BIT]};
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
        end
    end

    typeahead_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (bus.flush),
        .wdata_i (bus.kbd_in[KBD_CODE_W-1:0]),
        .rdata_o (head_code),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );
endmodule

// File: tb/tb_kbd_typeahead.sv
// Directed and randomized checks of kbd_typeahead against a queue-based model.
module tb_kbd_typeahead;
    localparam int unsigned DEPTH = 16;

    logic clock;
    logic reset_n;
    logic ack_en;
    int   checks;
    int   errors;

    kbd_typeahead_if #(.DEPTH(DEPTH)) bus ();

    kbd_typeahead #(
        .DEPTH        (DEPTH),
        .CLR_CYCLES   (4),
        .WAIT_TIMEOUT (255)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; the controller model then drops its strobe if acknowledged.
    task automatic tick();
        @(posedge clock);
        #1;
        if (ack_en && bus.kbd_clr_out) bus.kbd_in[7] = 1'b0;
    endtask

    task automatic press(input logic [6:0] code);
        bus.kbd_in = {1'b1, code};
        repeat (10) tick();
    endtask

    task automatic cpu_clear();
        bus.clr_strb = 1'b1;
        tick();
        bus.clr_strb = 1'b0;
    endtask

    initial begin
        int            hi;
        logic [6:0]    q[$];
        logic          m_ovf;
        logic [6:0]    code;
        logic [6:0]    keys[18];

        checks       = 0;
        errors       = 0;
        ack_en       = 1'b1;
        reset_n      = 1'b0;
        bus.kbd_in   = 8'hC1;
        bus.clr_strb = 1'b0;
        bus.flush    = 1'b0;

        // Reset with a stale strobe held by the controller
        repeat (3) @(posedge clock);
        #1;
        check("rst_dout", 32'(bus.dout), 32'h00);
        check("rst_count", 32'(bus.fifo_count), 0);
        check("rst_ovf", 32'(bus.overflow), 0);
        check("rst_clr", 32'(bus.kbd_clr_out), 1);
        reset_n = 1'b1;
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.kbd_clr_out) hi++;
            tick();
        end
        check("rst_clr_cycles", 32'(hi), 4);
        check("rst_no_push_dout", 32'(bus.dout), 32'h00);
        check("rst_no_push_count", 32'(bus.fifo_count), 0);
        check("rst_clr_low", 32'(bus.kbd_clr_out), 0);

        // Single key: latency and clear pulse width
        bus.kbd_in = 8'h41;
        tick();
        bus.kbd_in = 8'hC1;
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.kbd_clr_out) hi++;
            if (i == 2) check("lat_before", 32'(bus.dout), 32'h00);
            if (i == 3) check("lat_edge3", 32'(bus.dout), 32'hC1);
        end
        check("single_clr_cycles", 32'(hi), 4);
        cpu_clear();
        check("single_strb_clr", 32'(bus.dout), 32'h41);

        // Burst with no CPU reads
        press(7'h41);
        press(7'h42);
        press(7'h43);
        check("burst_head", 32'(bus.dout), 32'hC1);
        check("burst_count", 32'(bus.fifo_count), 2);
        cpu_clear();
        check("burst_gap", 32'(bus.dout), 32'h41);
        check("burst_gap_count", 32'(bus.fifo_count), 2);
        tick();
        check("burst_next", 32'(bus.dout), 32'hC2);
        check("burst_next_count", 32'(bus.fifo_count), 1);
        cpu_clear();
        tick();
        check("burst_last", 32'(bus.dout), 32'hC3);
        cpu_clear();
        check("burst_empty", 32'(bus.fifo_count), 0);

        // Overflow: 18 keys, head + 16 queued, last dropped
        for (int i = 0; i < 18; i++) begin
            keys[i] = 7'(i + 32'h30);
            press(keys[i]);
        end
        check("ovf_head", 32'(bus.dout), 32'({1'b1, keys[0]}));
        check("ovf_count", 32'(bus.fifo_count), DEPTH);
        check("ovf_flag", 32'(bus.overflow), 1);
        for (int k = 1; k < 17; k++) begin
            cpu_clear();
            tick();
            check($sformatf("ovf_drain%0d", k), 32'(bus.dout), 32'({1'b1, keys[k]}));
        end
        cpu_clear();
        tick();
        check("ovf_lost_key", 32'(bus.dout[7]), 0);
        check("ovf_sticky", 32'(bus.overflow), 1);

        // Flush colliding with a push, three keys queued
        press(7'h61);
        press(7'h62);
        press(7'h63);
        press(7'h64);
        check("flush_pre_count", 32'(bus.fifo_count), 3);
        bus.kbd_in = 8'hE5;
        tick();
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_count", 32'(bus.fifo_count), 0);
        check("flush_dout", 32'(bus.dout), 32'h61);
        check("flush_ovf", 32'(bus.overflow), 0);
        repeat (7) tick();
        check("flush_push_dropped", 32'(bus.fifo_count), 0);
        check("flush_no_strobe", 32'(bus.dout), 32'h61);

        // Controller ignores the clear: re-clear after the wait timeout
        ack_en = 1'b0;
        bus.kbd_in = 8'hDA;
        for (int i = 0; i <= 261; i++) begin
            tick();
            if (i == 3)   check("to_head", 32'(bus.dout), 32'hDA);
            if (i == 260) check("to_waiting", 32'(bus.kbd_clr_out), 0);
            if (i == 261) check("to_reclear", 32'(bus.kbd_clr_out), 1);
        end
        check("to_single_push", 32'(bus.fifo_count), 0);
        ack_en = 1'b1;
        repeat (20) tick();
        check("to_clr_released", 32'(bus.kbd_clr_out), 0);
        check("to_still_one", 32'(bus.fifo_count), 0);
        press(7'h5B);
        check("to_idle_again", 32'(bus.fifo_count), 1);

        // Randomized keys/reads/flushes vs a queue of keys the CPU has yet to consume
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        q = {};
        m_ovf = 1'b0;
        for (int n = 0; n < 40; n++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            if (r < 70) begin
                code = 7'($urandom_range(0, 127));
                press(code);
                if (q.size() < DEPTH + 1) q.push_back(code);
                else m_ovf = 1'b1;
            end else if (r < 95) begin
                cpu_clear();
                tick();
                if (q.size() > 0) void'(q.pop_front());
            end else begin
                bus.flush = 1'b1;
                tick();
                bus.flush = 1'b0;
                q = {};
                m_ovf = 1'b0;
            end
            check("rnd_count", 32'(bus.fifo_count), (q.size() > 0) ? q.size() - 1 : 0);
            check("rnd_strobe", 32'(bus.dout[7]), (q.size() > 0) ? 1 : 0);
            check("rnd_ovf", 32'(bus.overflow), 32'(m_ovf));
            if (q.size() > 0) check("rnd_head", 32'(bus.dout[6:0]), 32'(q[0]));
        end

        // Asynchronous reset mid-operation
        bus.kbd_in = 8'h00;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_dout", 32'(bus.dout), 32'h00);
        check("async_rst_clr", 32'(bus.kbd_clr_out), 1);
        check("async_rst_count", 32'(bus.fifo_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
